// File: rtl/downsample_stream.sv
// Streaming bilinear downsampler: buffers one HIN x HIN frame, then emits the
// HOUT x HOUT interpolated frame in raster order over a registered output stage.
module downsample_stream #(
   parameter int unsigned DW       = 8,
   parameter int unsigned CH       = 3,
   parameter int unsigned HIN      = 27,
   parameter int unsigned HOUT     = 19,
   parameter int unsigned FRAC     = 8,
   parameter int unsigned STRIDE_Q = 370
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CH*DW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH*DW-1:0] out_data,
   output logic             out_last
);

   localparam int unsigned PixW = CH * DW;
   localparam int unsigned RowW = (HIN > 1) ? $clog2(HIN) : 1;
   localparam int unsigned OutW = (HOUT > 1) ? $clog2(HOUT) : 1;
   localparam int unsigned PosW = $clog2(HIN) + FRAC + 1;
   localparam int unsigned IntW = PosW - FRAC;
   localparam int unsigned AccW = DW + 2 * FRAC + 2;

   localparam logic [RowW-1:0] InMax   = RowW'(HIN - 1);
   localparam logic [OutW-1:0] OutMax  = OutW'(HOUT - 1);
   localparam logic [PosW-1:0] Stride  = PosW'(STRIDE_Q);
   localparam logic [AccW-1:0] Scale   = AccW'(1) << FRAC;
   localparam logic [AccW-1:0] Half    = AccW'(1) << (2 * FRAC - 1);
   localparam logic [AccW-1:0] SampMax = AccW'({DW{1'b1}});

   if ((((HOUT - 1) * STRIDE_Q) >> FRAC) > HIN - 1) begin : g_bad_stride
      $error("downsample_stream: stride walks past the last input pixel");
   end

   typedef enum logic {StLoad, StCalc} state_e;

   state_e            state_q, state_d;
   logic [PixW-1:0]   frame_mem [HIN][HIN];
   logic [RowW-1:0]   row_q, col_q;
   logic [OutW-1:0]   oi_q, oj_q;
   logic [PosW-1:0]   ph_q, pw_q;
   logic              gen_done_q;

   logic              in_fire, out_fire, gen_fire, last_in;
   logic [IntW-1:0]   fh, fw;
   logic [FRAC-1:0]   y, x;
   logic [RowW-1:0]   fh_idx, fw_idx, ch_idx, cw_idx;
   logic [PixW-1:0]   a4, a3, a2, a1, pix;

   // Ceil index of a position, clamped to the last row/column.
   function automatic logic [RowW-1:0] ceil_idx(input logic [IntW-1:0] f, input logic nz);
      logic [IntW:0] s;
      s = {1'b0, f} + (IntW + 1)'(nz);
      if (s > (IntW + 1)'(HIN - 1)) begin
         return InMax;
      end
      return s[RowW-1:0];
   endfunction

   function automatic logic [DW-1:0] lerp(input logic [DW-1:0] p4, input logic [DW-1:0] p3,
                                          input logic [DW-1:0] p2, input logic [DW-1:0] p1,
                                          input logic [FRAC-1:0] fx, input logic [FRAC-1:0] fy);
      logic [AccW-1:0] xs, ys, top, bot, acc, v;
      xs  = AccW'(fx);
      ys  = AccW'(fy);
      top = AccW'(p4) * (Scale - xs) + AccW'(p3) * xs;
      bot = AccW'(p2) * (Scale - xs) + AccW'(p1) * xs;
      acc = top * (Scale - ys) + bot * ys;
      v   = (acc + Half) >> (2 * FRAC);
      if (v > SampMax) begin
         return {DW{1'b1}};
      end
      return v[DW-1:0];
   endfunction

   assign in_ready = rst_n & (state_q == StLoad);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign gen_fire = (state_q == StCalc) & (~out_valid | out_ready) & ~gen_done_q;
   assign last_in  = in_fire & (row_q == InMax) & (col_q == InMax);

   assign fh     = ph_q[PosW-1:FRAC];
   assign y      = ph_q[FRAC-1:0];
   assign fw     = pw_q[PosW-1:FRAC];
   assign x      = pw_q[FRAC-1:0];
   assign fh_idx = fh[RowW-1:0];
   assign fw_idx = fw[RowW-1:0];
   assign ch_idx = ceil_idx(fh, y != '0);
   assign cw_idx = ceil_idx(fw, x != '0);

   assign a4 = frame_mem[fh_idx][fw_idx];
   assign a3 = frame_mem[fh_idx][cw_idx];
   assign a2 = frame_mem[ch_idx][fw_idx];
   assign a1 = frame_mem[ch_idx][cw_idx];

   always_comb begin
      pix = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         pix[k*DW +: DW] = lerp(a4[k*DW +: DW], a3[k*DW +: DW], a2[k*DW +: DW],
                                a1[k*DW +: DW], x, y);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StLoad:  if (last_in) state_d = StCalc;
         StCalc:  if (out_fire && out_last) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   // Frame buffer is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         frame_mem[row_q][col_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StLoad;
         row_q      <= '0;
         col_q      <= '0;
         oi_q       <= '0;
         oj_q       <= '0;
         ph_q       <= '0;
         pw_q       <= '0;
         gen_done_q <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (in_fire) begin
            if (col_q == InMax) begin
               col_q <= '0;
               row_q <= (row_q == InMax) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end

         if (gen_fire) begin
            out_valid <= 1'b1;
            out_data  <= pix;
            out_last  <= (oi_q == OutMax) && (oj_q == OutMax);
            if (oj_q == OutMax) begin
               oj_q <= '0;
               pw_q <= '0;
               if (oi_q == OutMax) begin
                  oi_q       <= '0;
                  ph_q       <= '0;
                  gen_done_q <= 1'b1;
               end else begin
                  oi_q <= oi_q + 1'b1;
                  ph_q <= ph_q + Stride;
               end
            end else begin
               oj_q <= oj_q + 1'b1;
               pw_q <= pw_q + Stride;
            end
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         if (out_fire && out_last) begin
            gen_done_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_downsample_stream.sv
// Scoreboard bench: default-size instance for frame, backpressure and reset tests,
// plus three small instances with hand-computed outputs.
module tb_downsample_stream;

   localparam int DW = 8, CH = 3, HIN = 27, HOUT = 19, FRAC = 8, STRIDE_Q = 370;
   localparam int PW = CH * DW;
   localparam int NOUT = HOUT * HOUT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [PW-1:0] in_data, out_data;

   logic       s_in_valid  [3];
   logic       s_in_ready  [3];
   logic [7:0] s_in_data   [3];
   logic       s_out_valid [3];
   logic       s_out_ready [3];
   logic [7:0] s_out_data  [3];
   logic       s_out_last  [3];

   int checks = 0;
   int errors = 0;

   logic [PW-1:0] exp_data_q[$];
   bit            exp_last_q[$];
   logic [PW-1:0] frame [HIN][HIN];
   int            s_in[$];
   int            s_exp[$];

   downsample_stream #(.DW(DW), .CH(CH), .HIN(HIN), .HOUT(HOUT), .FRAC(FRAC),
                       .STRIDE_Q(STRIDE_Q)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

   downsample_stream #(.DW(8), .CH(1), .HIN(2), .HOUT(2), .FRAC(8), .STRIDE_Q(128)) u_half (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
      .in_data(s_in_data[0]), .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]),
      .out_data(s_out_data[0]), .out_last(s_out_last[0]));

   downsample_stream #(.DW(8), .CH(1), .HIN(5), .HOUT(3), .FRAC(8), .STRIDE_Q(512)) u_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
      .in_data(s_in_data[1]), .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]),
      .out_data(s_out_data[1]), .out_last(s_out_last[1]));

   downsample_stream #(.DW(8), .CH(1), .HIN(4), .HOUT(4), .FRAC(8), .STRIDE_Q(256)) u_id (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[2]), .in_ready(s_in_ready[2]),
      .in_data(s_in_data[2]), .out_valid(s_out_valid[2]), .out_ready(s_out_ready[2]),
      .out_data(s_out_data[2]), .out_last(s_out_last[2]));

   // Reference: direct multiply positions, then the bilinear formula per channel.
   function automatic logic [PW-1:0] model_pix(input int i, input int j);
      int ph, pw, fh, fw, yy, xx, chh, cw;
      longint a4, a3, a2, a1, acc, v;
      logic [PW-1:0] r;
      ph = i * STRIDE_Q;
      pw = j * STRIDE_Q;
      fh = ph >> FRAC;
      fw = pw >> FRAC;
      yy = ph % (1 << FRAC);
      xx = pw % (1 << FRAC);
      chh = (yy != 0) ? fh + 1 : fh;
      cw  = (xx != 0) ? fw + 1 : fw;
      if (chh > HIN - 1) chh = HIN - 1;
      if (cw > HIN - 1) cw = HIN - 1;
      r = '0;
      for (int k = 0; k < CH; k++) begin
         a4 = longint'(frame[fh][fw][k*DW +: DW]);
         a3 = longint'(frame[fh][cw][k*DW +: DW]);
         a2 = longint'(frame[chh][fw][k*DW +: DW]);
         a1 = longint'(frame[chh][cw][k*DW +: DW]);
         acc = (a4 * (256 - xx) + a3 * xx) * (256 - yy) + (a2 * (256 - xx) + a1 * xx) * yy;
         v = (acc + 32768) >> 16;
         if (v > 255) v = 255;
         r[k*DW +: DW] = v[7:0];
      end
      return r;
   endfunction

   task automatic fill_frame(input int mode);
      for (int r = 0; r < HIN; r++) begin
         for (int c = 0; c < HIN; c++) begin
            case (mode)
               0:       frame[r][c] = {3{8'd100}};
               1:       frame[r][c] = {8'(255 - r * 5 - c), 8'(r * 9 + c * 7), 8'(r * c)};
               default: frame[r][c] = PW'($urandom);
            endcase
         end
      end
   endtask

   task automatic load_frame();
      int guard;
      for (int r = 0; r < HIN; r++) begin
         for (int c = 0; c < HIN; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame[r][c];
            guard = 0;
            while (!in_ready && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
               $display("FAIL load_in_ready r=%0d c=%0d: got %b want 1", r, c, in_ready);
               errors++;
               in_valid = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < HOUT; i++) begin
         for (int j = 0; j < HOUT; j++) begin
            exp_data_q.push_back(model_pix(i, j));
            exp_last_q.push_back(i == HOUT - 1 && j == HOUT - 1);
         end
      end
   endtask

   task automatic collect(input string name, input int n, input int stall_at,
                          input int stall_len, input bit junk, output int got);
      int cyc, stalled;
      logic [PW-1:0] held, ed;
      bit el;
      got = 0;
      cyc = 0;
      stalled = 0;
      held = '0;
      if (junk) begin
         in_valid = 1'b1;
         in_data  = '1;
      end
      while (got < n && cyc < 3000) begin
         checks++;
         if (in_ready !== 1'b0) begin
            $display("FAIL %s_in_ready_calc: got %b want 0", name, in_ready);
            errors++;
         end
         if (got == stall_at && stalled < stall_len && out_valid) begin
            if (stalled == 0) begin
               held = out_data;
            end else begin
               checks++;
               if (out_data !== held || out_valid !== 1'b1) begin
                  $display("FAIL %s_hold: got %h/%b want %h/1", name, out_data, out_valid, held);
                  errors++;
               end
            end
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
            if (out_valid) begin
               checks++;
               if (exp_data_q.size() == 0) begin
                  $display("FAIL %s_extra_output: got %h want none", name, out_data);
                  errors++;
               end else begin
                  ed = exp_data_q.pop_front();
                  el = exp_last_q.pop_front();
                  if (out_data !== ed) begin
                     $display("FAIL %s_data #%0d: got %h want %h", name, got, out_data, ed);
                     errors++;
                  end
                  checks++;
                  if (out_last !== el) begin
                     $display("FAIL %s_last #%0d: got %b want %b", name, got, out_last, el);
                     errors++;
                  end
               end
               got++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != n) begin
         $display("FAIL %s_count: got %0d outputs want %0d", name, got, n);
         errors++;
      end
   endtask

   task automatic check_frame_end(input string name);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL %s_end: got in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
         errors++;
      end
      checks++;
      if (exp_data_q.size() != 0) begin
         $display("FAIL %s_missing: got %0d left want 0", name, exp_data_q.size());
         errors++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_in_valid[k] = 1'b0;
         s_in_data[k] = '0;
         s_out_ready[k] = 1'b1;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
         $display("FAIL reset_values: got rdy=%b vld=%b last=%b data=%h want 0/0/0/0",
                  in_ready, out_valid, out_last, out_data);
         errors++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
         errors++;
      end
   endtask

   task automatic test_const_latency();
      int got;
      fill_frame(0);
      load_frame();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         $display("FAIL latency_calc_entry: got rdy=%b vld=%b want 0/0", in_ready, out_valid);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         $display("FAIL latency_first_valid: got %b want 1", out_valid);
         errors++;
      end
      collect("const", NOUT, -1, 0, 1'b0, got);
      check_frame_end("const");
   endtask

   task automatic test_backpressure();
      int got;
      fill_frame(1);
      load_frame();
      collect("bp", NOUT, 100, 5, 1'b1, got);
      check_frame_end("bp");
   endtask

   task automatic test_reset_mid_calc();
      int got;
      fill_frame(2);
      load_frame();
      collect("pre_rst", 10, -1, 0, 1'b0, got);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         $display("FAIL mid_reset: got vld=%b rdy=%b want 0/0", out_valid, in_ready);
         errors++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL mid_reset_release: got in_ready=%b want 1", in_ready);
         errors++;
      end
      exp_data_q.delete();
      exp_last_q.delete();
      fill_frame(1);
      load_frame();
      collect("post_rst", NOUT, -1, 0, 1'b0, got);
      check_frame_end("post_rst");
   endtask

   task automatic test_small(input int k, input string name);
      int got, cyc, n, e;
      got = 0;
      cyc = 0;
      n = s_exp.size();
      while (s_in.size() > 0) begin
         @(negedge clk);
         s_in_valid[k] = 1'b1;
         s_in_data[k]  = 8'(s_in.pop_front());
         checks++;
         if (s_in_ready[k] !== 1'b1) begin
            $display("FAIL %s_in_ready: got %b want 1", name, s_in_ready[k]);
            errors++;
         end
      end
      @(negedge clk);
      s_in_valid[k] = 1'b0;
      while (got < n && cyc < 200) begin
         if (s_out_valid[k]) begin
            e = s_exp.pop_front();
            checks++;
            if (s_out_data[k] !== 8'(e)) begin
               $display("FAIL %s_data #%0d: got %0d want %0d", name, got, s_out_data[k], e);
               errors++;
            end
            checks++;
            if (s_out_last[k] !== (s_exp.size() == 0)) begin
               $display("FAIL %s_last #%0d: got %b want %b", name, got, s_out_last[k],
                        s_exp.size() == 0);
               errors++;
            end
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (got != n || s_in_ready[k] !== 1'b1) begin
         $display("FAIL %s_end: got %0d outputs rdy=%b want %0d/1", name, got, s_in_ready[k], n);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_const_latency();
      test_backpressure();
      test_reset_mid_calc();

      s_in  = '{0, 100, 200, 44};
      s_exp = '{0, 50, 100, 86};
      test_small(0, "half_step");

      s_in.delete();
      for (int i = 0; i < 25; i++) s_in.push_back(i);
      s_exp = '{0, 2, 4, 10, 12, 14, 20, 22, 24};
      test_small(1, "stride2");

      s_in.delete();
      s_exp.delete();
      for (int i = 0; i < 16; i++) begin
         s_in.push_back(i);
         s_exp.push_back(i);
      end
      test_small(2, "identity");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
